// File: rtl/data_mem_sized.sv
// Byte-addressed data memory for the MIPS MEM stage: byte/half/word access,
// sign/zero-extended loads, 1-cycle registered read, fault flagging, post-reset clear.
module data_mem_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Fault,
  output logic        Ready
);

  localparam int W = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_AFTER_RESET = INIT_CLEAR ? ST_INIT : ST_RUN;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_clr_idx;
  logic [W-1:0]   w_clr_idx_nxt;
  logic           r_ready;
  logic [31:0]    r_read_data;
  logic           r_read_valid;
  logic           r_fault;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_req;
  logic           w_fault;
  logic           w_misaligned;
  logic           w_load_ok;
  logic           w_store_ok;
  logic [W-1:0]   w_idx;
  logic [31:0]    w_word;
  logic [31:0]    w_shift;
  logic [31:0]    w_load;
  logic           w_mem_we;
  logic [W-1:0]   w_mem_idx;
  logic [31:0]    w_mem_data;
  logic [3:0]     w_mem_be;

  // Next-state logic: clear one word per cycle, leave INIT after the last index.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_INIT: begin
        w_clr_idx_nxt = r_clr_idx + W'(1);
        if (r_clr_idx == W'(DEPTH_WORDS - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_AFTER_RESET;
    endcase
  end

  // FSM state, clear counter and Ready register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_AFTER_RESET;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ready   <= (w_state_nxt == ST_RUN);
    end
  end

  // Request decode and fault detection; faults only matter for accepted requests.
  always_comb begin
    w_req = r_ready & (MemRead | MemWrite);
    case (Size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = Address[0];
      2'b10:   w_misaligned = |Address[1:0];
      default: w_misaligned = 1'b1;
    endcase
    w_fault    = (|Address[31:W+2]) | w_misaligned;
    w_load_ok  = w_req & MemRead & ~w_fault;
    w_store_ok = w_req & MemWrite & ~w_fault;
    w_idx      = Address[W+1:2];
  end

  // Read-before-write: the load sees the array contents before this edge's store.
  always_comb begin
    w_word  = r_mem[w_idx];
    w_shift = w_word >> {Address[1:0], 3'b000};
    case (Size)
      2'b00:   w_load = Unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = Unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_word;
    endcase
  end

  // Array write port: zero-fill during INIT, lane-masked store in RUN.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = w_idx;
    w_mem_data = 32'd0;
    w_mem_be   = 4'b0000;
    if (r_state == ST_INIT) begin
      w_mem_we  = 1'b1;
      w_mem_idx = r_clr_idx;
      w_mem_be  = 4'b1111;
    end else if (w_store_ok) begin
      w_mem_we = 1'b1;
      case (Size)
        2'b00: begin
          w_mem_data = {4{WriteData[7:0]}};
          w_mem_be   = 4'b0001 << Address[1:0];
        end
        2'b01: begin
          w_mem_data = {2{WriteData[15:0]}};
          w_mem_be   = Address[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_mem_data = WriteData;
          w_mem_be   = 4'b1111;
        end
      endcase
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // Storage array; nothing is written in a reset cycle.
  always_ff @(posedge clock) begin
    if (!reset && w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= w_mem_data[8*i +: 8];
        end
      end
    end
  end

  // Registered load result and single-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data  <= 32'd0;
      r_read_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_read_valid <= w_load_ok;
      r_fault      <= w_req & w_fault;
      if (w_load_ok) begin
        r_read_data <= w_load;
      end
    end
  end

  assign ReadData  = r_read_data;
  assign ReadValid = r_read_valid;
  assign Fault     = r_fault;
  assign Ready     = r_ready;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench for data_mem_sized (DEPTH_WORDS=256, INIT_CLEAR=1).
module tb_data_mem_sized;

  logic        clock;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Fault;
  logic        Ready;

  int n_assert;
  int n_fail;
  int cnt;
  logic seen_pulse;

  data_mem_sized #(.DEPTH_WORDS(256), .INIT_CLEAR(1'b1)) dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .ReadValid(ReadValid), .Fault(Fault), .Ready(Ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single clock edge; returns at the following negedge.
  task automatic acc(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
    @(negedge clock);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    acc(1'b1, 1'b0, sz, uns, addr, 32'h0);
    chk(tag, ReadData, exp);
    chk({tag, ".valid"}, {31'd0, ReadValid}, 32'd1);
    chk({tag, ".fault"}, {31'd0, Fault}, 32'd0);
  endtask

  task automatic fault_chk(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] hold);
    acc(rd, wr, sz, 1'b0, addr, 32'hFFFF_FFFF);
    chk({tag, ".fault"}, {31'd0, Fault}, 32'd1);
    chk({tag, ".valid"}, {31'd0, ReadValid}, 32'd0);
    chk({tag, ".hold"}, ReadData, hold);
  endtask

  // Count negedges with Ready low; bounded so a stuck design still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 1000) begin
      if (ReadValid !== 1'b0 || Fault !== 1'b0) seen_pulse = 1'b1;
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; seen_pulse = 1'b0;
    reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; Size = 2'b10; Unsigned = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.rdata", ReadData, 32'h0);
    chk("rst.valid", {31'd0, ReadValid}, 32'd0);
    chk("rst.fault", {31'd0, Fault}, 32'd0);
    chk("rst.ready", {31'd0, Ready}, 32'd0);

    // 1: INIT length, requests ignored during clear, cleared word reads zero
    reset = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b1; Size = 2'b10; Address = 32'h3FC; WriteData = 32'hAAAA_AAAA;
    wait_ready(cnt);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("init.len", cnt, 32'd256);
    chk("init.nopulse", {31'd0, seen_pulse}, 32'd0);
    load_chk("ld3fc", 2'b10, 1'b0, 32'h3FC, 32'h0);
    @(negedge clock);
    chk("idle.valid", {31'd0, ReadValid}, 32'd0);
    chk("idle.fault", {31'd0, Fault}, 32'd0);

    // 2: word store then extended loads
    acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("st10.valid", {31'd0, ReadValid}, 32'd0);
    chk("st10.fault", {31'd0, Fault}, 32'd0);
    load_chk("ldw10", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    load_chk("ldb11s", 2'b00, 1'b0, 32'h11, 32'hFFFF_FFBE);
    load_chk("ldb11u", 2'b00, 1'b1, 32'h11, 32'h0000_00BE);
    load_chk("ldh12s", 2'b01, 1'b0, 32'h12, 32'hFFFF_DEAD);
    load_chk("ldh12u", 2'b01, 1'b1, 32'h12, 32'h0000_DEAD);
    load_chk("ldb10s", 2'b00, 1'b0, 32'h10, 32'hFFFF_FFEF);
    load_chk("ldh10s", 2'b01, 1'b0, 32'h10, 32'hFFFF_BEEF);
    load_chk("ldw10u", 2'b10, 1'b1, 32'h10, 32'hDEAD_BEEF);

    // 3: partial stores touch only their lanes; upper WriteData bits are ignored
    acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF55);
    load_chk("ldw10.b", 2'b10, 1'b0, 32'h10, 32'h55AD_BEEF);
    acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD_1234);
    load_chk("ldw10.h", 2'b10, 1'b0, 32'h10, 32'h55AD_1234);

    // 4: faults leave memory and ReadData untouched
    fault_chk("f.stw12", 1'b0, 1'b1, 2'b10, 32'h12, 32'h55AD_1234);
    fault_chk("f.ldh11", 1'b1, 1'b0, 2'b01, 32'h11, 32'h55AD_1234);
    fault_chk("f.ld400", 1'b1, 1'b0, 2'b10, 32'h400, 32'h55AD_1234);
    fault_chk("f.st410", 1'b0, 1'b1, 2'b10, 32'h410, 32'h55AD_1234);
    fault_chk("f.sz11", 1'b0, 1'b1, 2'b11, 32'h10, 32'h55AD_1234);
    fault_chk("f.sthb", 1'b0, 1'b1, 2'b00, 32'h8000_0010, 32'h55AD_1234);
    @(negedge clock);
    chk("f.pulse1", {31'd0, Fault}, 32'd0);
    load_chk("ldw10.f", 2'b10, 1'b0, 32'h10, 32'h55AD_1234);

    // 5: simultaneous read and write returns the old contents
    acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111);
    acc(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h2222_2222);
    chk("rw20.old", ReadData, 32'h1111_1111);
    chk("rw20.valid", {31'd0, ReadValid}, 32'd1);
    load_chk("ldw20.new", 2'b10, 1'b0, 32'h20, 32'h2222_2222);

    // 6: reset mid-INIT restarts the full clear
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    chk("init100.ready", {31'd0, Ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen_pulse = 1'b0;
    wait_ready(cnt);
    chk("reinit.len", cnt, 32'd256);
    chk("reinit.nopulse", {31'd0, seen_pulse}, 32'd0);

    // 6: reset right after a store drops the pending load pulse and clears data
    acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
    MemRead = 1'b1; Size = 2'b10; Address = 32'h30; reset = 1'b1;
    @(negedge clock);
    MemRead = 1'b0;
    chk("rstld.valid", {31'd0, ReadValid}, 32'd0);
    chk("rstld.rdata", ReadData, 32'h0);
    chk("rstld.ready", {31'd0, Ready}, 32'd0);
    reset = 1'b0;
    wait_ready(cnt);
    chk("rerun.len", cnt, 32'd256);
    load_chk("ldw30.clr", 2'b10, 1'b0, 32'h30, 32'h0);
    load_chk("ldw10.clr", 2'b10, 1'b0, 32'h10, 32'h0);
    load_chk("ldw20.clr", 2'b10, 1'b0, 32'h20, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
